mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 128 ++++++++++++
 tb/tb_mem_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for load data, extends it and hands off to WB.
// Optional MS_FWD_DATA_EN widens ms_to_ds_bus with final_result for ID-stage forwarding.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [75:0] es_to_ms_bus,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
`ifdef MS_FWD_DATA_EN
    output logic [39:0] ms_to_ds_bus
`else
    output logic [7:0]  ms_to_ds_bus
`endif
);

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } ld_type_e;

    logic        ms_valid;
    logic        buf_valid;
    logic [75:0] payload;
    logic [31:0] buf_data;

    ld_type_e    ld_type;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        unused_pad;

    logic        ms_ready_go;
    logic        leave;
    logic        buf_capture;
    logic [31:0] load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] final_result;
    logic [7:0]  ds_ctrl;

    // Bits [33:32] of the incoming bus carry no field.
    assign ld_type      = ld_type_e'(payload[75:73]);
    assign res_from_mem = payload[72];
    assign gr_we        = payload[71];
    assign dest         = payload[70:66];
    assign alu_result   = payload[65:34];
    assign pc           = payload[31:0];
    assign unused_pad   = ^payload[33:32];

    assign ms_ready_go    = !res_from_mem || data_sram_data_ok || buf_valid;
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign leave          = ms_to_ws_valid && ws_allowin;
    assign buf_capture    = ms_valid && res_from_mem && !buf_valid
                            && data_sram_data_ok && !ws_allowin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid  <= 1'b0;
            buf_valid <= 1'b0;
        end else begin
            if (ms_allowin)
                ms_valid <= es_to_ms_valid;
            if (leave)
                buf_valid <= 1'b0;
            else if (buf_capture)
                buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin)
            payload <= es_to_ms_bus;
        if (buf_capture)
            buf_data <= data_sram_rdata;
    end

    assign load_data = buf_valid ? buf_data : data_sram_rdata;
    assign half_sel  = alu_result[1] ? load_data[31:16] : load_data[15:0];

    always_comb begin
        byte_sel = load_data[7:0];
        case (alu_result[1:0])
            2'd1:    byte_sel = load_data[15:8];
            2'd2:    byte_sel = load_data[23:16];
            2'd3:    byte_sel = load_data[31:24];
            default: byte_sel = load_data[7:0];
        endcase
    end

    // Unlisted ld_type encodings fall through to a full-word load.
    always_comb begin
        load_ext = load_data;
        case (ld_type)
            LD_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   load_ext = {24'b0, byte_sel};
            LD_H:    load_ext = {{16{half_sel[15]}}, half_sel};
            LD_HU:   load_ext = {16'b0, half_sel};
            default: load_ext = load_data;
        endcase
    end

    assign final_result = res_from_mem ? load_ext : alu_result;
    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

    assign ds_ctrl = {ms_valid,
                      ms_valid && gr_we,
                      ms_valid ? dest : 5'b0,
                      ms_valid && res_from_mem && !ms_ready_go};

`ifdef MS_FWD_DATA_EN
    assign ms_to_ds_bus = {final_result, ds_ctrl};
`else
    assign ms_to_ds_bus = ds_ctrl;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
`ifdef MS_FWD_DATA_EN
    logic [39:0] ms_to_ds_bus;
`else
    logic [7:0]  ms_to_ds_bus;
`endif

    int tests = 0;
    int fails = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ds_bus      (ms_to_ds_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  t;
        logic        rfm;
        logic        gwe;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc;
    } ins_t;

    function automatic logic [75:0] mk_bus(input logic [2:0] t, input logic rfm, input logic gwe,
                                           input logic [4:0] dest, input logic [31:0] alu,
                                           input logic [31:0] pc, input logic [1:0] pad);
        return {t, rfm, gwe, dest, alu, pad, pc};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] addr,
                                             input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * addr[1:0])) & 32'hFF;
        h = (d >> (16 * addr[1])) & 32'hFFFF;
        case (t)
            3'b001:  return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            3'b010:  return b;
            3'b011:  return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            3'b100:  return h;
            default: return d;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        ws_allowin        = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        es_to_ms_bus    = '0;
        data_sram_rdata = '0;
        #1;
        tests++; if (ms_allowin !== 1'b1) begin fails++; $display("FAIL rst_allowin: got %b want 1", ms_allowin); end
        tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL rst_ws_valid: got %b want 0", ms_to_ws_valid); end
        tests++; if (ms_to_ds_bus[7:0] !== 8'h00) begin fails++; $display("FAIL rst_ds_bus: got %h want 00", ms_to_ds_bus[7:0]); end
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_non_load();
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(3'b000, 1'b0, 1'b1, 5'd5, 32'h00001234, 32'h1C000010, 2'b00);
        #2;
        tests++; if (ms_allowin !== 1'b1) begin fails++; $display("FAIL nl_allowin: got %b want 1", ms_allowin); end
        tick();
        es_to_ms_valid = 1'b0;
        #2;
        tests++; if (ms_to_ws_valid !== 1'b1) begin fails++; $display("FAIL nl_valid: got %b want 1", ms_to_ws_valid); end
        tests++; if (ms_to_ws_bus !== {1'b1, 5'd5, 32'h00001234, 32'h1C000010}) begin fails++; $display("FAIL nl_bus: got %h want %h", ms_to_ws_bus, {1'b1, 5'd5, 32'h00001234, 32'h1C000010}); end
        tests++; if (ms_to_ds_bus[7:0] !== 8'b1100_1010) begin fails++; $display("FAIL nl_ds_bus: got %b want 11001010", ms_to_ds_bus[7:0]); end
        tick();
        #2;
        tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL nl_drained: got %b want 0", ms_to_ws_valid); end
    endtask

    task automatic test_lb_late();
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(3'b001, 1'b1, 1'b1, 5'd7, 32'h00000102, 32'h1C000020, 2'b00);
        for (int i = 0; i < 2; i++) begin
            tick();
            es_to_ms_valid    = 1'b0;
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = $urandom;
            #2;
            tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL lb_wait_valid[%0d]: got %b want 0", i, ms_to_ws_valid); end
            tests++; if (ms_to_ds_bus[0] !== 1'b1) begin fails++; $display("FAIL lb_pending[%0d]: got %b want 1", i, ms_to_ds_bus[0]); end
            tests++; if (ms_allowin !== 1'b0) begin fails++; $display("FAIL lb_allowin[%0d]: got %b want 0", i, ms_allowin); end
        end
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h12F45678;
        #2;
        tests++; if (ms_to_ws_valid !== 1'b1) begin fails++; $display("FAIL lb_valid: got %b want 1", ms_to_ws_valid); end
        tests++; if (ms_to_ws_bus[63:32] !== 32'hFFFFFFF4) begin fails++; $display("FAIL lb_result: got %h want FFFFFFF4", ms_to_ws_bus[63:32]); end
        tests++; if (ms_to_ds_bus[0] !== 1'b0) begin fails++; $display("FAIL lb_pending_clr: got %b want 0", ms_to_ds_bus[0]); end
        tick();
        idle();
        #2;
        tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL lb_drained: got %b want 0", ms_to_ws_valid); end
    endtask

    task automatic test_lhu_buf();
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(3'b100, 1'b1, 1'b1, 5'd9, 32'h00000002, 32'h1C000030, 2'b00);
        tick();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001ABCD;
        #2;
        tests++; if (ms_to_ws_bus[63:32] !== 32'h00008001) begin fails++; $display("FAIL lhu_first: got %h want 00008001", ms_to_ws_bus[63:32]); end
        tests++; if (ms_allowin !== 1'b0) begin fails++; $display("FAIL lhu_stall0: got %b want 0", ms_allowin); end
        for (int i = 0; i < 2; i++) begin
            tick();
            data_sram_data_ok = (i == 0);
            data_sram_rdata   = 32'hDEADBEEF;
            #2;
            tests++; if (ms_to_ws_valid !== 1'b1) begin fails++; $display("FAIL lhu_hold_valid[%0d]: got %b want 1", i, ms_to_ws_valid); end
            tests++; if (ms_to_ws_bus[63:32] !== 32'h00008001) begin fails++; $display("FAIL lhu_hold[%0d]: got %h want 00008001", i, ms_to_ws_bus[63:32]); end
            tests++; if (ms_allowin !== 1'b0) begin fails++; $display("FAIL lhu_stall[%0d]: got %b want 0", i, ms_allowin); end
        end
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk_bus(3'b000, 1'b1, 1'b1, 5'd10, 32'h00000000, 32'h1C000034, 2'b00);
        #2;
        tests++; if (ms_to_ws_bus[63:32] !== 32'h00008001) begin fails++; $display("FAIL lhu_release: got %h want 00008001", ms_to_ws_bus[63:32]); end
        tests++; if (ms_allowin !== 1'b1) begin fails++; $display("FAIL lhu_allowin: got %b want 1", ms_allowin); end
        tick();
        es_to_ms_valid = 1'b0;
        #2;
        tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL swap_buf_cleared: got %b want 0", ms_to_ws_valid); end
        tests++; if (ms_to_ds_bus[0] !== 1'b1) begin fails++; $display("FAIL swap_pending: got %b want 1", ms_to_ds_bus[0]); end
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h13579BDF;
        #2;
        tests++; if (ms_to_ws_bus[63:32] !== 32'h13579BDF) begin fails++; $display("FAIL swap_result: got %h want 13579BDF", ms_to_ws_bus[63:32]); end
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(3'b000, 1'b1, 1'b1, 5'd3, 32'h00000040, 32'h1C000040, 2'b00);
        tick();
        es_to_ms_bus      = mk_bus(3'b000, 1'b0, 1'b1, 5'd4, 32'h000055AA, 32'h1C000044, 2'b00);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFEF00D;
        #2;
        tests++; if (ms_to_ws_valid !== 1'b1) begin fails++; $display("FAIL b2b_lw_valid: got %b want 1", ms_to_ws_valid); end
        tests++; if (ms_to_ws_bus[63:32] !== 32'hCAFEF00D) begin fails++; $display("FAIL b2b_lw_result: got %h want CAFEF00D", ms_to_ws_bus[63:32]); end
        tests++; if (ms_allowin !== 1'b1) begin fails++; $display("FAIL b2b_allowin: got %b want 1", ms_allowin); end
        tick();
        es_to_ms_bus    = mk_bus(3'b000, 1'b1, 1'b0, 5'd6, 32'h00000044, 32'h1C000048, 2'b00);
        data_sram_rdata = 32'h11111111;
        #2;
        tests++; if (ms_to_ws_valid !== 1'b1) begin fails++; $display("FAIL b2b_nl_valid: got %b want 1", ms_to_ws_valid); end
        tests++; if (ms_to_ws_bus !== {1'b1, 5'd4, 32'h000055AA, 32'h1C000044}) begin fails++; $display("FAIL b2b_nl_bus: got %h want %h", ms_to_ws_bus, {1'b1, 5'd4, 32'h000055AA, 32'h1C000044}); end
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        #2;
        tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL b2b_no_buf: got %b want 0", ms_to_ws_valid); end
        tests++; if (ms_to_ds_bus[7:0] !== 8'b1000_1101) begin fails++; $display("FAIL b2b_ds_bus: got %b want 10001101", ms_to_ds_bus[7:0]); end
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h22222222;
        #2;
        tests++; if (ms_to_ws_bus[63:32] !== 32'h22222222) begin fails++; $display("FAIL b2b_last: got %h want 22222222", ms_to_ws_bus[63:32]); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_load();
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(3'b000, 1'b1, 1'b1, 5'd8, 32'h00000080, 32'h1C000050, 2'b00);
        tick();
        es_to_ms_valid = 1'b0;
        #2;
        tests++; if (ms_to_ds_bus[0] !== 1'b1) begin fails++; $display("FAIL rml_pending: got %b want 1", ms_to_ds_bus[0]); end
        #1;
        reset = 1'b1;
        #1;
        tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL rml_valid: got %b want 0", ms_to_ws_valid); end
        tests++; if (ms_allowin !== 1'b1) begin fails++; $display("FAIL rml_allowin: got %b want 1", ms_allowin); end
        tests++; if (ms_to_ds_bus[7:0] !== 8'h00) begin fails++; $display("FAIL rml_ds_bus: got %h want 00", ms_to_ds_bus[7:0]); end
        tick(); tick();
        reset             = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BADF00D;
        #2;
        tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL rml_stray: got %b want 0", ms_to_ws_valid); end
        tick();
        data_sram_data_ok = 1'b0;
        #2;
        tests++; if (ms_to_ds_bus[7:0] !== 8'h00) begin fails++; $display("FAIL rml_after: got %h want 00", ms_to_ds_bus[7:0]); end
    endtask

    task automatic test_random();
        ins_t        cur;
        ins_t        nxt;
        logic        occ  = 1'b0;
        logic        got  = 1'b0;
        logic [31:0] gdata = '0;
        logic        ready, exp_valid, exp_allowin, exp_pending;
        logic [31:0] data, exp_final;
        logic [7:0]  exp_ds;
        cur = '{t: 3'b0, rfm: 1'b0, gwe: 1'b0, dest: 5'b0, alu: 32'b0, pc: 32'b0};
        for (int n = 0; n < 400; n++) begin
            tick();
            nxt.t    = 3'($urandom_range(0, 7));
            nxt.rfm  = 1'($urandom_range(0, 1));
            nxt.gwe  = 1'($urandom_range(0, 1));
            nxt.dest = 5'($urandom);
            nxt.alu  = $urandom;
            nxt.pc   = $urandom;
            es_to_ms_valid    = ($urandom_range(0, 9) < 6);
            es_to_ms_bus      = mk_bus(nxt.t, nxt.rfm, nxt.gwe, nxt.dest, nxt.alu, nxt.pc, 2'($urandom));
            data_sram_data_ok = ($urandom_range(0, 1) == 1);
            data_sram_rdata   = $urandom;
            ws_allowin        = ($urandom_range(0, 9) < 7);

            ready       = !cur.rfm || got || data_sram_data_ok;
            data        = got ? gdata : data_sram_rdata;
            exp_final   = cur.rfm ? ref_load(cur.t, cur.alu, data) : cur.alu;
            exp_valid   = occ && ready;
            exp_allowin = !occ || (ready && ws_allowin);
            exp_pending = occ && !ready;
            exp_ds      = occ ? {1'b1, cur.gwe, cur.dest, exp_pending} : 8'h00;
            #2;
            tests++; if (ms_to_ws_valid !== exp_valid) begin fails++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, ms_to_ws_valid, exp_valid); end
            tests++; if (ms_allowin !== exp_allowin) begin fails++; $display("FAIL rnd_allowin[%0d]: got %b want %b", n, ms_allowin, exp_allowin); end
            tests++; if (ms_to_ds_bus[7:0] !== exp_ds) begin fails++; $display("FAIL rnd_ds_bus[%0d]: got %b want %b", n, ms_to_ds_bus[7:0], exp_ds); end
            if (exp_valid) begin
                tests++; if (ms_to_ws_bus !== {cur.gwe, cur.dest, exp_final, cur.pc}) begin fails++; $display("FAIL rnd_ws_bus[%0d]: got %h want %h", n, ms_to_ws_bus, {cur.gwe, cur.dest, exp_final, cur.pc}); end
            end
`ifdef MS_FWD_DATA_EN
            if (occ && !exp_pending) begin
                tests++; if (ms_to_ds_bus[39:8] !== exp_final) begin fails++; $display("FAIL rnd_fwd[%0d]: got %h want %h", n, ms_to_ds_bus[39:8], exp_final); end
            end
`endif
            if (exp_allowin) begin
                occ = es_to_ms_valid;
                got = 1'b0;
                if (es_to_ms_valid) cur = nxt;
            end else if (occ && cur.rfm && !got && data_sram_data_ok) begin
                got   = 1'b1;
                gdata = data_sram_rdata;
            end
        end
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_non_load();
        test_lb_late();
        test_lhu_buf();
        test_back_to_back();
        test_reset_mid_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
